// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// ALU control codes, condition codes and decode field values.
package cu_pkg;

  localparam int unsigned ALU_CODE_W = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned COND_W     = 4;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
  } state_t;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_ORR = 4'b0011;
  localparam logic [ALU_CODE_W-1:0] ALU_LSL = 4'b1000;
  localparam logic [ALU_CODE_W-1:0] ALU_LSR = 4'b1010;
  localparam logic [ALU_CODE_W-1:0] ALU_ASR = 4'b1011;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_AND   = 4'b0000;
  localparam logic [3:0] CMD_SUB   = 4'b0010;
  localparam logic [3:0] CMD_ADD   = 4'b0100;
  localparam logic [3:0] CMD_CMP   = 4'b1010;
  localparam logic [3:0] CMD_ORR   = 4'b1100;
  localparam logic [3:0] CMD_SHIFT = 4'b1101;

  // ShiftSel[2:1] to shifter code; 11 aliases ASR
  function automatic logic [ALU_CODE_W-1:0] shift_alu(input logic [1:0] sel);
    case (sel)
      2'b00:   return ALU_LSL;
      2'b01:   return ALU_LSR;
      default: return ALU_ASR;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction/flag inputs and datapath control outputs.
// The slave modport is the control unit, the master modport the datapath side.
interface multicycle_control_unit_if #(parameter int unsigned ALUW = 4) ();
  logic [31:0]     instr;
  logic [3:0]      alu_flags;
  logic            pc_write;
  logic            adr_src;
  logic            mem_w;
  logic            ir_write;
  logic            reg_w;
  logic [1:0]      result_src;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      imm_src;
  logic [2:0]      reg_src;
  logic [ALUW-1:0] alu_control;
  logic [3:0]      flags;
  logic            busy;

  modport master (
    output instr, alu_flags,
    input  pc_write, adr_src, mem_w, ir_write, reg_w, result_src, alu_src_a,
           alu_src_b, imm_src, reg_src, alu_control, flags, busy
  );

  modport slave (
    input  instr, alu_flags,
    output pc_write, adr_src, mem_w, ir_write, reg_w, result_src, alu_src_a,
           alu_src_b, imm_src, reg_src, alu_control, flags, busy
  );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator, shared with the pipelined core.
module cond_check
  import cu_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        flags,
  output logic              cond_ex_c
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex_c = 1'b0;
    case (cond)
      COND_EQ: cond_ex_c = z;
      COND_NE: cond_ex_c = ~z;
      COND_CS: cond_ex_c = c;
      COND_CC: cond_ex_c = ~c;
      COND_MI: cond_ex_c = n;
      COND_PL: cond_ex_c = ~n;
      COND_VS: cond_ex_c = v;
      COND_VC: cond_ex_c = ~v;
      COND_HI: cond_ex_c = c & ~z;
      COND_LS: cond_ex_c = ~c | z;
      COND_GE: cond_ex_c = (n == v);
      COND_LT: cond_ex_c = (n != v);
      COND_GT: cond_ex_c = ~z & (n == v);
      COND_LE: cond_ex_c = z | (n != v);
      COND_AL: cond_ex_c = 1'b1;
      COND_NV: cond_ex_c = 1'b0;
      default: cond_ex_c = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequencing FSM with memory-latency wait counter,
// NZCV flag register and conditional execution latched in DECODE.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned ALUW    = 4,
  parameter int unsigned MEM_LAT = 1,
  parameter bit          COND_EN = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_unit_if.slave bus
);

  if (ALUW < 4) begin : g_bad_aluw
    $error("ALUW must be at least 4");
  end
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("MEM_LAT must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              flags_q;
  logic                    cond_ex;
  logic                    cond_ok_c;

  logic [1:0]              op;
  logic                    imm;
  logic [3:0]              cmd;
  logic                    s_bit;
  logic [ALU_CODE_W-1:0]   dp_alu;
  logic                    dp_wr;
  logic                    dp_cmp;
  logic                    cnt_last;
  logic                    unused_instr;

  assign op       = bus.instr[27:26];
  assign imm      = bus.instr[25];
  assign cmd      = bus.instr[24:21];
  assign s_bit    = bus.instr[20];
  assign cnt_last = (cnt == LAT_LAST);
  assign unused_instr = ^{bus.instr[19:7], bus.instr[4:0]};

  cond_check u_cond (
    .cond      (bus.instr[31:28]),
    .flags     (flags_q),
    .cond_ex_c (cond_ok_c)
  );

  // Data-processing decode; unlisted commands run as ADD without writeback
  always_comb begin
    dp_alu = ALU_ADD;
    dp_wr  = 1'b0;
    dp_cmp = 1'b0;
    case (cmd)
      CMD_ADD:   begin dp_alu = ALU_ADD; dp_wr = 1'b1; end
      CMD_SUB:   begin dp_alu = ALU_SUB; dp_wr = 1'b1; end
      CMD_AND:   begin dp_alu = ALU_AND; dp_wr = 1'b1; end
      CMD_ORR:   begin dp_alu = ALU_ORR; dp_wr = 1'b1; end
      CMD_CMP:   begin dp_alu = ALU_SUB; dp_cmp = 1'b1; end
      CMD_SHIFT: begin dp_alu = shift_alu(bus.instr[6:5]); dp_wr = 1'b1; end
      default:   begin dp_alu = ALU_ADD; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      cnt     <= '0;
      flags_q <= '0;
      cond_ex <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= S_DECODE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          cond_ex <= COND_EN ? cond_ok_c : 1'b1;
          case (op)
            OP_DP:   state <= imm ? S_EXECI : S_EXECR;
            OP_MEM:  state <= S_MEMADR;
            OP_BR:   state <= S_BRANCH;
            OP_NOP:  state <= S_FETCH;
            default: state <= S_FETCH;
          endcase
        end
        S_EXECR, S_EXECI: begin
          if ((s_bit | dp_cmp) && cond_ex) flags_q <= bus.alu_flags;
          state <= S_ALUWB;
        end
        S_MEMADR: state <= s_bit ? S_MEMRD : S_MEMWR;
        S_MEMRD, S_MEMWR: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= (state == S_MEMRD) ? S_MEMWB : S_FETCH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  logic                  pc_write_c, ir_write_c, reg_w_c, mem_w_c;
  logic                  adr_src_c, alu_src_a_c;
  logic [1:0]            result_src_c, alu_src_b_c;
  logic [ALU_CODE_W-1:0] alu_c;

  // Moore decode of the current state; every signal starts inactive
  always_comb begin
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_w_c      = 1'b0;
    mem_w_c      = 1'b0;
    adr_src_c    = 1'b0;
    alu_src_a_c  = 1'b0;
    result_src_c = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_c        = ALU_ADD;
    case (state)
      S_FETCH: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = cnt_last;
        pc_write_c   = cnt_last;
      end
      S_EXECR:  alu_c = dp_alu;
      S_EXECI: begin
        alu_c       = dp_alu;
        alu_src_b_c = 2'b01;
      end
      S_ALUWB:  reg_w_c = cond_ex & dp_wr;
      S_MEMADR: alu_src_b_c = 2'b01;
      S_MEMRD:  adr_src_c = 1'b1;
      S_MEMWB: begin
        reg_w_c      = cond_ex;
        result_src_c = 2'b01;
      end
      S_MEMWR: begin
        adr_src_c = 1'b1;
        mem_w_c   = cond_ex;
      end
      S_BRANCH: begin
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b10;
        pc_write_c   = cond_ex;
      end
      default: ;
    endcase
  end

  // Enables are forced low straight from reset so an aborted access never writes
  assign bus.pc_write    = pc_write_c & ~rst;
  assign bus.ir_write    = ir_write_c & ~rst;
  assign bus.reg_w       = reg_w_c & ~rst;
  assign bus.mem_w       = mem_w_c & ~rst;
  assign bus.adr_src     = adr_src_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.result_src  = result_src_c;
  assign bus.alu_control = ALUW'(alu_c);
  assign bus.imm_src     = op;
  assign bus.reg_src     = {(op == OP_DP) && (cmd == CMD_SHIFT),
                            (op == OP_MEM) && !s_bit,
                            (op == OP_BR)};
  assign bus.flags       = flags_q;
  assign bus.busy        = (state != S_FETCH);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit: per-cycle expected
// control vectors for a conditional (dut0) and an unconditional (dut1) instance.
module tb_multicycle_control_unit;

  localparam int LAT = 3;

  logic clk;
  logic rst;

  multicycle_control_unit_if #(.ALUW(4)) bus0 ();
  multicycle_control_unit_if #(.ALUW(4)) bus1 ();
  multicycle_control_unit_if #(.ALUW(4)) bus2 ();

  multicycle_control_unit #(.ALUW(4), .MEM_LAT(LAT), .COND_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  multicycle_control_unit #(.ALUW(4), .MEM_LAT(LAT), .COND_EN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  multicycle_control_unit #(.ALUW(4), .MEM_LAT(1), .COND_EN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, pcw, irw, regw, memw, adrsrc, resultsrc[2], srca, srcb[2], aluctl[4], flags[4]}
  logic [18:0] obs0, obs1;
  assign obs0 = {bus0.busy, bus0.pc_write, bus0.ir_write, bus0.reg_w, bus0.mem_w,
                 bus0.adr_src, bus0.result_src, bus0.alu_src_a, bus0.alu_src_b,
                 bus0.alu_control, bus0.flags};
  assign obs1 = {bus1.busy, bus1.pc_write, bus1.ir_write, bus1.reg_w, bus1.mem_w,
                 bus1.adr_src, bus1.result_src, bus1.alu_src_a, bus1.alu_src_b,
                 bus1.alu_control, bus1.flags};

  typedef struct {
    string       tag;
    logic [18:0] e0;
    logic [18:0] e1;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [18:0] v(input logic busy, pcw, irw, rw, mw, adr,
                                    input logic [1:0] rs, input logic sa,
                                    input logic [1:0] sb, input logic [3:0] alu,
                                    input logic [3:0] fl);
    return {busy, pcw, irw, rw, mw, adr, rs, sa, sb, alu, fl};
  endfunction

  function automatic logic [18:0] fetch_v(input logic last, input logic [3:0] fl);
    return v(1'b0, last, last, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 4'b0000, fl);
  endfunction
  function automatic logic [18:0] decode_v(input logic [3:0] fl);
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, fl);
  endfunction
  function automatic logic [18:0] exec_v(input logic im, input logic [3:0] alu, input logic [3:0] fl);
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, {1'b0, im}, alu, fl);
  endfunction
  function automatic logic [18:0] aluwb_v(input logic rw, input logic [3:0] fl);
    return v(1'b1, 1'b0, 1'b0, rw, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, fl);
  endfunction
  function automatic logic [18:0] memadr_v(input logic [3:0] fl);
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0000, fl);
  endfunction
  function automatic logic [18:0] memrd_v(input logic [3:0] fl);
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, fl);
  endfunction
  function automatic logic [18:0] memwb_v(input logic rw, input logic [3:0] fl);
    return v(1'b1, 1'b0, 1'b0, rw, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 4'b0000, fl);
  endfunction
  function automatic logic [18:0] memwr_v(input logic mw, input logic [3:0] fl);
    return v(1'b1, 1'b0, 1'b0, 1'b0, mw, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, fl);
  endfunction
  function automatic logic [18:0] branch_v(input logic pcw, input logic [3:0] fl);
    return v(1'b1, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 4'b0000, fl);
  endfunction

  task automatic push(input string tag, input logic [18:0] e0, input logic [18:0] e1);
    exp_t e;
    e.tag = tag;
    e.e0  = e0;
    e.e1  = e1;
    q.push_back(e);
  endtask

  task automatic push_same(input string tag, input logic [18:0] e);
    push(tag, e, e);
  endtask

  task automatic push_fetch(input string tag, input logic [3:0] fl);
    for (int i = 0; i < LAT; i++) push_same({tag, "_fetch"}, fetch_v(i == LAT - 1, fl));
  endtask

  task automatic check();
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_underflow observed %05h expected none", obs0);
      return;
    end
    e = q.pop_front();
    vectors++;
    assert (obs0 === e.e0) else begin
      miscompares++;
      $error("FAIL %s dut0 observed %05h expected %05h", e.tag, obs0, e.e0);
    end
    vectors++;
    assert (obs1 === e.e1) else begin
      miscompares++;
      $error("FAIL %s dut1 observed %05h expected %05h", e.tag, obs1, e.e1);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      check();
    end
  endtask

  task automatic set_instr(input logic [31:0] ins);
    bus0.instr = ins;
    bus1.instr = ins;
  endtask

  task automatic set_aluflags(input logic [3:0] fl);
    bus0.alu_flags = fl;
    bus1.alu_flags = fl;
  endtask

  // Instruction fetch begins on the next edge; first fetch cycle checked there
  task automatic start_instr(input logic [31:0] ins);
    tick();
    set_instr(ins);
    check();
  endtask

  task automatic alu_instr(input string tag, input logic [31:0] ins, input logic im,
                           input logic [3:0] alu, input logic [3:0] fl_pre,
                           input logic [3:0] fl_post, input logic rw0, input logic rw1);
    push_fetch(tag, fl_pre);
    push_same({tag, "_decode"}, decode_v(fl_pre));
    push_same({tag, "_exec"}, exec_v(im, alu, fl_pre));
    push({tag, "_wb"}, aluwb_v(rw0, fl_post), aluwb_v(rw1, fl_post));
    start_instr(ins);
    run(5);
  endtask

  initial begin
    rst = 1'b1;
    set_instr(32'h0);
    set_aluflags(4'b0000);
    bus2.instr     = 32'h0;
    bus2.alu_flags = 4'b0000;
    repeat (3) tick();
    push_same("in_reset", fetch_v(1'b0, 4'b0000));
    check();
    check_bit("reset_irw_lat1", bus2.ir_write, 1'b0);
    check_bit("reset_pcw_lat1", bus2.pc_write, 1'b0);

    // ADD R1,R2,R3 straight out of reset: FETCH x3, DECODE, EXECR, ALUWB
    set_instr(32'hE0821003);
    push_fetch("add", 4'b0000);
    push_same("add_decode", decode_v(4'b0000));
    push_same("add_exec", exec_v(1'b0, 4'b0000, 4'b0000));
    push_same("add_wb", aluwb_v(1'b1, 4'b0000));
    rst = 1'b0;
    #1;
    check();
    check_bit("lat1_first_fetch_irw", bus2.ir_write, 1'b1);
    run(5);

    set_aluflags(4'b0100);
    alu_instr("subs", 32'hE0521003, 1'b0, 4'b0001, 4'b0000, 4'b0100, 1'b1, 1'b1);
    set_aluflags(4'b1111);
    alu_instr("addeq", 32'h00821003, 1'b0, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b1);
    alu_instr("addne", 32'h10821003, 1'b0, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1);
    set_aluflags(4'b0010);
    alu_instr("cmp_s0", 32'hE1420003, 1'b0, 4'b0001, 4'b0100, 4'b0010, 1'b0, 1'b0);
    alu_instr("lsr", 32'hE1A01023, 1'b0, 4'b1010, 4'b0010, 4'b0010, 1'b1, 1'b1);
    alu_instr("asr", 32'hE1A01063, 1'b0, 4'b1011, 4'b0010, 4'b0010, 1'b1, 1'b1);
    alu_instr("addi", 32'hE2821005, 1'b1, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1);
    alu_instr("eor_other", 32'hE0221003, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b0);

    // LDR: MEMADR, MEM_LAT read cycles, writeback
    push_fetch("ldr", 4'b0010);
    push_same("ldr_decode", decode_v(4'b0010));
    push_same("ldr_adr", memadr_v(4'b0010));
    for (int i = 0; i < LAT; i++) push_same("ldr_rd", memrd_v(4'b0010));
    push_same("ldr_wb", memwb_v(1'b1, 4'b0010));
    start_instr(32'hE5921004);
    run(5 + LAT);

    // STR: write enable held for MEM_LAT cycles
    push_fetch("str", 4'b0010);
    push_same("str_decode", decode_v(4'b0010));
    push_same("str_adr", memadr_v(4'b0010));
    for (int i = 0; i < LAT; i++) push_same("str_wr", memwr_v(1'b1, 4'b0010));
    start_instr(32'hE5821004);
    run(4 + LAT);

    // Branch with Cond=1111: suppressed only when conditions are evaluated
    push_fetch("b_nv", 4'b0010);
    push_same("b_nv_decode", decode_v(4'b0010));
    push("b_nv_branch", branch_v(1'b0, 4'b0010), branch_v(1'b1, 4'b0010));
    start_instr(32'hFA000000);
    run(4);

    // STR interrupted by reset in its second write cycle
    push_fetch("str_abort", 4'b0010);
    push_same("str_abort_decode", decode_v(4'b0010));
    push_same("str_abort_adr", memadr_v(4'b0010));
    push_same("str_abort_wr", memwr_v(1'b1, 4'b0010));
    push_same("str_abort_wr", memwr_v(1'b1, 4'b0010));
    start_instr(32'hE5821004);
    run(6);
    #2;
    rst = 1'b1;
    #1;
    push_same("rst_async", fetch_v(1'b0, 4'b0000));
    check();
    push_same("rst_edge", fetch_v(1'b0, 4'b0000));
    tick();
    check();

    set_instr(32'hE0821003);
    push_fetch("add_after_rst", 4'b0000);
    push_same("add_after_rst_decode", decode_v(4'b0000));
    push_same("add_after_rst_exec", exec_v(1'b0, 4'b0000, 4'b0000));
    push_same("add_after_rst_wb", aluwb_v(1'b1, 4'b0000));
    rst = 1'b0;
    #1;
    check();
    run(5);

    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle control unit of the Filter-GPU ARM-subset core.
- Adds a sequencing FSM, a parametrised memory-latency wait counter, an NZCV flag register and full conditional execution.
- Keeps the same decode and shift-ALU-control encodings, so the existing datapath (ALU, register file, extender) is reused.
- Sits between the instruction register / ALU flags and the datapath mux and enable controls.

Parameters:
- ALUW, 4, ALUControl width; values below 4 are illegal.
- MEM_LAT, 1, cycles per memory access, range 1..15; a 4-bit wait counter covers the range.
- COND_EN, 1, 1 = evaluate Cond; 0 = every instruction executes (AL).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Instr  in  32  instruction register contents
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  0 = PC, 1 = ALU result register
- MemW  out  1  data-memory write enable
- IRWrite  out  1  instruction-register load
- RegW  out  1  register-file write
- ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALU direct
- ALUSrcA  out  1  0 = Rn, 1 = PC
- ALUSrcB  out  2  00 Rm, 01 Ext, 10 constant 4
- ImmSrc  out  2  = Instr[27:26]
- RegSrc  out  3  {shift flag, Op==01 & ~L, Op==10}
- ALUControl  out  ALUW  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 1000 LSL, 1010 LSR, 1011 ASR
- Flags  out  4  registered NZCV
- Busy  out  1  high whenever state != FETCH

Behaviour:
- Reset (asynchronous): state=FETCH, wait counter=0, Flags=0000, CondEx register=0. All enables are 0 while RST is high.
- States: FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH.
- Decode fields: Op=Instr[27:26], I=Instr[25], cmd=Instr[24:21], S=Instr[20], L=Instr[20], ShiftSel=Instr[6:4].
- Opcode map for Op=00:
  - cmd 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - cmd 1010 CMP: SUB with RegW suppressed and S forced to 1.
  - cmd 1101 shift: ALUControl from ShiftSel[2:1]: 00 LSL, 01 LSR, 10 ASR, 11 ASR.
  - Any other cmd executes as ADD with RegW suppressed.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - The wait counter increments each cycle.
  - On the cycle where counter==MEM_LAT-1: IRWrite=1, PCWrite=1, counter clears, next state DECODE.
- DECODE:
  - CondEx register <= condition(Cond, Flags), forced to 1 when COND_EN=0.
  - Next state: Op 00 with I=0 -> EXECR; Op 00 with I=1 -> EXECI; Op 01 -> MEMADR; Op 10 -> BRANCH; Op 11 -> FETCH (NOP).
- EXECR / EXECI:
  - ALU operation per decode; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - If S & CondEx: Flags <= ALUFlags at the end of this cycle.
  - Next state: ALUWB.
- ALUWB: RegW = CondEx & ~CMP, ResultSrc=00. Next state FETCH.
- MEMADR: ADD, ALUSrcB=01. Next state MEMRD if L, else MEMWR.
- MEMRD: AdrSrc=1. Waits MEM_LAT cycles on the counter, then MEMWB.
- MEMWB: RegW=CondEx, ResultSrc=01. Next state FETCH.
- MEMWR: AdrSrc=1, MemW=CondEx, held for MEM_LAT cycles. Next state FETCH.
- BRANCH: ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Next state FETCH.
- Condition evaluation (ARM codes):
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 evaluates to 0.
- Outputs not listed for a state are 0 in that state.
- RST mid-access aborts immediately, with no partial write.
- A flag update and a condition evaluation never land in the same cycle, because the latch happens in DECODE.

Decomposition:
- Package cu_pkg holds:
  - state enum;
  - ALUControl localparams;
  - Cond codes;
  - Op codes and cmd codes.
- Sub-module cond_check: combinational (Cond, Flags) -> CondEx. It is reused by the pipelined core.

Test Plan:
- Reset while in MEMWR with MEM_LAT=3 -> MemW drops asynchronously; state=FETCH and Flags=0000 at the next edge.
- MEM_LAT=3, ADD R1,R2,R3 (Instr 0xE0821003):
  - IRWrite high in cycle 3 only.
  - Sequence FETCH x3, DECODE, EXECR, ALUWB.
  - RegW=1 in the ALUWB cycle; 6 cycles total.
- SUBS with ALUFlags=0100, then ADDEQ:
  - Flags=0100 after EXECR.
  - The ADDEQ writes: RegW=1.
- Same sequence with ADDNE -> RegW stays 0 throughout.
- LSR with ShiftSel=010 -> ALUControl=1010 in EXECR. ShiftSel=110 -> ALUControl=1011.
- Branch with Cond=1111 -> PCWrite=0 in BRANCH. With COND_EN=0 the same instruction -> PCWrite=1.
